wb_initiator: RTL and testbench

Wishbone classic initiator that turns single load/store requests from a core-side valid/ready port into one Wishbone transfer each. It targets the team's no-stall, no-error Wishbone responders such as the on-chip RAM. It performs byte-lane steering on writes and extraction plus sign extension on loads. It detects misaligned accesses and reports bus timeouts as errors. It sits between a CPU load/store or fetch unit and the bus; data width is fixed at 32 bits with byte granularity.

---
 rtl/wb_initiator.sv | 246 ++++++++++++++++++++++++
 tb/tb_wb_initiator.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_initiator.sv
// -----------------------------------------------------------------------------
// wb_initiator
//
// Wishbone classic initiator. It turns each load/store request from a core-side
// valid/ready port into exactly one Wishbone transfer.
//   - Stores: the right-aligned write data is replicated across the byte lanes,
//     and sel_o marks the lanes the responder must write.
//   - Loads: the addressed byte or half-word is extracted from dat_i and then
//     zero- or sign-extended.
//   - Misaligned or reserved-size requests get an error response. No bus cycle
//     is issued for them.
//   - A transfer that sees no ack for TIMEOUT cycles is abandoned with an error.
//
// Parameters
//   A_WIDTH       word-address width on the bus (byte address is A_WIDTH+2)
//   TIMEOUT       BUS-state cycles without ack before giving up (>= 1)
//
// Ports
//   clk_i         clock, rising edge
//   rst_i         synchronous active-high reset
//   req_valid_i   core request valid
//   req_ready_o   initiator can accept a request (high only in IDLE)
//   req_addr_i    byte address
//   req_we_i      1 = store, 0 = load
//   req_size_i    00 byte, 01 half, 10 word, 11 reserved
//   req_signed_i  sign-extend the load result (ignored for word loads)
//   req_wdata_i   right-aligned store data
//   resp_valid_o  one-cycle response strobe
//   resp_data_o   right-aligned, extended load data; 0 for stores and errors
//   resp_err_o    misaligned / reserved size / timeout
//   adr_o         Wishbone word address
//   dat_o         Wishbone write data
//   dat_i         Wishbone read data
//   sel_o         Wishbone byte lane selects
//   we_o          Wishbone write enable
//   stb_o         Wishbone strobe
//   cyc_o         Wishbone cycle (always equal to stb_o)
//   ack_i         Wishbone acknowledge
// -----------------------------------------------------------------------------
module wb_initiator #(
  parameter int A_WIDTH = 8,
  parameter int TIMEOUT = 15
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               req_valid_i,
  output logic               req_ready_o,
  input  logic [A_WIDTH+1:0] req_addr_i,
  input  logic               req_we_i,
  input  logic [1:0]         req_size_i,
  input  logic               req_signed_i,
  input  logic [31:0]        req_wdata_i,
  output logic               resp_valid_o,
  output logic [31:0]        resp_data_o,
  output logic               resp_err_o,
  output logic [A_WIDTH-1:0] adr_o,
  output logic [31:0]        dat_o,
  input  logic [31:0]        dat_i,
  output logic [3:0]         sel_o,
  output logic               we_o,
  output logic               stb_o,
  output logic               cyc_o,
  input  logic               ack_i
);

  // The counter only has to reach TIMEOUT-1. The increment in the final BUS
  // cycle may wrap, but RESP clears the counter before it is used again.
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUS  = 2'b01,
    ST_RESP = 2'b10
  } state_t;

  state_t           state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [1:0]       size_r;
  logic [1:0]       off_r;
  logic             signed_r;

  // Byte lane selects for a given size and byte offset. Half-words are
  // always aligned when this is used, so the shift only ever gives 0011 or 1100.
  function automatic logic [3:0] lane_sel(input logic [1:0] size,
                                          input logic [1:0] off);
    logic [3:0] sel;
    case (size)
      SZ_BYTE: sel = 4'b0001 << off;
      SZ_HALF: sel = 4'b0011 << off;
      SZ_WORD: sel = 4'b1111;
      default: sel = 4'b0000;
    endcase
    return sel;
  endfunction

  // Replicate right-aligned store data so every selected lane carries it.
  function automatic logic [31:0] lane_data(input logic [1:0]  size,
                                            input logic [31:0] wdata);
    logic [31:0] d;
    case (size)
      SZ_BYTE: d = {4{wdata[7:0]}};
      SZ_HALF: d = {2{wdata[15:0]}};
      SZ_WORD: d = wdata;
      default: d = 32'h0000_0000;
    endcase
    return d;
  endfunction

  // A request is rejected for a reserved size, or when it is not naturally aligned.
  function automatic logic req_bad(input logic [1:0] size,
                                   input logic [1:0] off);
    logic bad;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = off[0];
      SZ_WORD: bad = (off != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

  // Pull the addressed byte or half-word out of the read word, then extend it.
  function automatic logic [31:0] load_extract(input logic [1:0]  size,
                                               input logic [1:0]  off,
                                               input logic        sgn,
                                               input logic [31:0] data);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = data[{off, 3'b000} +: 8];
    h = off[1] ? data[31:16] : data[15:0];
    case (size)
      SZ_BYTE: r = {{24{sgn & b[7]}}, b};
      SZ_HALF: r = {{16{sgn & h[15]}}, h};
      SZ_WORD: r = data;
      default: r = 32'h0000_0000;
    endcase
    return r;
  endfunction

  // Transfer FSM: request accept, bus phase with timeout, one-cycle response.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r      <= ST_IDLE;
      cnt_r        <= CNT_ZERO;
      size_r       <= 2'b00;
      off_r        <= 2'b00;
      signed_r     <= 1'b0;
      req_ready_o  <= 1'b1;
      resp_valid_o <= 1'b0;
      resp_data_o  <= 32'h0000_0000;
      resp_err_o   <= 1'b0;
      adr_o        <= {A_WIDTH{1'b0}};
      dat_o        <= 32'h0000_0000;
      sel_o        <= 4'b0000;
      we_o         <= 1'b0;
      stb_o        <= 1'b0;
      cyc_o        <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          stb_o        <= 1'b0;
          cyc_o        <= 1'b0;
          resp_valid_o <= 1'b0;
          cnt_r        <= CNT_ZERO;
          if (req_valid_i) begin
            req_ready_o <= 1'b0;
            size_r      <= req_size_i;
            off_r       <= req_addr_i[1:0];
            signed_r    <= req_signed_i;
            if (req_bad(req_size_i, req_addr_i[1:0])) begin
              // Rejected requests go straight to the response and never touch the bus.
              resp_valid_o <= 1'b1;
              resp_err_o   <= 1'b1;
              resp_data_o  <= 32'h0000_0000;
              state_r      <= ST_RESP;
            end else begin
              adr_o   <= req_addr_i[A_WIDTH+1:2];
              dat_o   <= lane_data(req_size_i, req_wdata_i);
              sel_o   <= lane_sel(req_size_i, req_addr_i[1:0]);
              we_o    <= req_we_i;
              stb_o   <= 1'b1;
              cyc_o   <= 1'b1;
              state_r <= ST_BUS;
            end
          end else begin
            req_ready_o <= 1'b1;
            state_r     <= ST_IDLE;
          end
        end

        ST_BUS: begin
          cnt_r <= cnt_r + CNT_ONE;
          if (ack_i) begin
            // An ack in the same cycle as the timeout wins.
            stb_o        <= 1'b0;
            cyc_o        <= 1'b0;
            resp_valid_o <= 1'b1;
            resp_err_o   <= 1'b0;
            resp_data_o  <= we_o ? 32'h0000_0000
                                 : load_extract(size_r, off_r, signed_r, dat_i);
            state_r      <= ST_RESP;
          end else if (cnt_r == CNT_LAST) begin
            stb_o        <= 1'b0;
            cyc_o        <= 1'b0;
            resp_valid_o <= 1'b1;
            resp_err_o   <= 1'b1;
            resp_data_o  <= 32'h0000_0000;
            state_r      <= ST_RESP;
          end else begin
            stb_o   <= 1'b1;
            cyc_o   <= 1'b1;
            state_r <= ST_BUS;
          end
        end

        ST_RESP: begin
          // A trailing registered ack may land here; RESP never looks at ack_i.
          stb_o        <= 1'b0;
          cyc_o        <= 1'b0;
          resp_valid_o <= 1'b0;
          req_ready_o  <= 1'b1;
          cnt_r        <= CNT_ZERO;
          state_r      <= ST_IDLE;
        end

        default: begin
          stb_o        <= 1'b0;
          cyc_o        <= 1'b0;
          resp_valid_o <= 1'b0;
          req_ready_o  <= 1'b1;
          cnt_r        <= CNT_ZERO;
          state_r      <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_initiator.sv
// -----------------------------------------------------------------------------
// tb_wb_initiator
//
// Drives wb_initiator against a small Wishbone RAM model with three responder
// behaviours:
//   - single-cycle registered ack
//   - ack held for two cycles
//   - never ack
//
// Vectors come from a table. Expected responses and bus phases are queued when
// a request is accepted, and a monitor compares them when the DUT produces them.
// -----------------------------------------------------------------------------
module tb_wb_initiator;

  localparam logic [1:0] M_ONE  = 2'd0;
  localparam logic [1:0] M_HOLD = 2'd1;
  localparam logic [1:0] M_NONE = 2'd2;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [9:0]  req_addr;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        resp_err;
  logic [7:0]  adr;
  logic [31:0] dat_o;
  logic [31:0] dat_i;
  logic [3:0]  sel;
  logic        we;
  logic        stb;
  logic        cyc;
  logic        ack;

  wb_initiator #(.A_WIDTH(8), .TIMEOUT(15)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_addr_i(req_addr), .req_we_i(req_we), .req_size_i(req_size),
    .req_signed_i(req_signed), .req_wdata_i(req_wdata),
    .resp_valid_o(resp_valid), .resp_data_o(resp_data), .resp_err_o(resp_err),
    .adr_o(adr), .dat_o(dat_o), .dat_i(dat_i), .sel_o(sel), .we_o(we),
    .stb_o(stb), .cyc_o(cyc), .ack_i(ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------- responder
  logic [1:0]  mode;
  logic [31:0] mem [0:255];

  always @(posedge clk) begin
    case (mode)
      M_ONE:   ack <= stb & cyc & ~ack;
      M_HOLD:  ack <= stb & cyc;
      default: ack <= 1'b0;
    endcase
    dat_i <= mem[adr];
    if (stb && cyc && we && mode != M_NONE)
      for (int i = 0; i < 4; i++)
        if (sel[i]) mem[adr][8*i +: 8] <= dat_o[8*i +: 8];
  end

  // ---------------------------------------------------------------- bookkeeping
  int n_cmp  = 0;
  int n_fail = 0;
  int cyc_cnt = 0;

  initial forever begin
    @(posedge clk);
    cyc_cnt++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc_cnt);
    end
  endtask

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          cyc;
  } rs_t;

  typedef struct {
    logic [7:0]  adr;
    logic [3:0]  sel;
    logic        we;
    logic [31:0] dat;
    int          len;
  } bs_t;

  rs_t resp_q[$];
  bs_t bus_q[$];

  // ---------------------------------------------------------------- monitor
  initial begin
    logic        stb_prev = 1'b0;
    logic        cur_ok   = 1'b0;
    bs_t         cur;
    int          run_len  = 0;
    logic [7:0]  p_adr    = 8'h00;
    logic [3:0]  p_sel    = 4'h0;
    logic [31:0] p_dat    = 32'h0;
    logic        p_we     = 1'b0;
    rs_t         r;
    forever begin
      @(negedge clk);
      if (cyc !== stb) chk("cyc_eq_stb", {31'd0, cyc}, {31'd0, stb});
      if (stb === 1'b1 && !stb_prev) begin
        if (bus_q.size() == 0) begin
          chk("unexpected_stb", 32'd1, 32'd0);
          cur_ok = 1'b0;
        end else begin
          cur = bus_q.pop_front();
          cur_ok = 1'b1;
          chk("adr_o", {24'd0, adr}, {24'd0, cur.adr});
          chk("sel_o", {28'd0, sel}, {28'd0, cur.sel});
          chk("we_o", {31'd0, we}, {31'd0, cur.we});
          if (cur.we) chk("dat_o", dat_o, cur.dat);
        end
        run_len = 1;
      end else if (stb === 1'b1 && stb_prev) begin
        run_len++;
        if ({adr, sel, dat_o, we} !== {p_adr, p_sel, p_dat, p_we})
          chk("bus_hold", {adr, sel, 20'd0}, {p_adr, p_sel, 20'd0});
      end else if (stb_prev && cur_ok) begin
        chk("stb_len", run_len, cur.len);
        cur_ok = 1'b0;
      end
      stb_prev = (stb === 1'b1);
      p_adr = adr; p_sel = sel; p_dat = dat_o; p_we = we;

      if (resp_valid === 1'b1) begin
        if (resp_q.size() == 0) begin
          chk("unexpected_resp", 32'd1, 32'd0);
        end else begin
          r = resp_q.pop_front();
          chk("resp_data", resp_data, r.data);
          chk("resp_err", {31'd0, resp_err}, {31'd0, r.err});
          chk("resp_cycle", cyc_cnt, r.cyc);
        end
      end
    end
  end

  // ---------------------------------------------------------------- vectors
  typedef struct {
    logic [1:0]  mode;
    logic        we;
    logic [1:0]  size;
    logic        sgn;
    logic [9:0]  addr;
    logic [31:0] wdata;
    logic        bus;
    logic [3:0]  sel;
    logic [31:0] dat;
    int          len;
    logic [31:0] rdata;
    logic        err;
  } vec_t;

  function automatic vec_t v(input logic [1:0] m, input logic w, input logic [1:0] sz,
                             input logic sg, input logic [9:0] a, input logic [31:0] wd,
                             input logic b, input logic [3:0] s, input logic [31:0] d,
                             input int l, input logic [31:0] rd, input logic e);
    vec_t t;
    t.mode = m; t.we = w; t.size = sz; t.sgn = sg; t.addr = a; t.wdata = wd;
    t.bus = b; t.sel = s; t.dat = d; t.len = l; t.rdata = rd; t.err = e;
    return t;
  endfunction

  task automatic do_req(input vec_t t);
    bit   got = 1'b0;
    rs_t  r;
    bs_t  b;
    mode = t.mode;
    @(posedge clk); #1;
    req_we = t.we; req_size = t.size; req_signed = t.sgn;
    req_addr = t.addr; req_wdata = t.wdata; req_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (req_ready === 1'b1) begin got = 1'b1; break; end
    end
    if (!got) begin
      chk("ready_wait", 32'd0, 32'd1);
      req_valid = 1'b0;
      return;
    end
    r.data = t.rdata; r.err = t.err;
    r.cyc = cyc_cnt + (t.bus ? t.len + 1 : 1);
    resp_q.push_back(r);
    if (t.bus) begin
      b.adr = t.addr[9:2]; b.sel = t.sel; b.we = t.we; b.dat = t.dat; b.len = t.len;
      bus_q.push_back(b);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (resp_q.size() == 0) break;
      @(negedge clk);
    end
    if (resp_q.size() != 0) begin
      chk("resp_wait", resp_q.size(), 32'd0);
      resp_q.delete();
      bus_q.delete();
    end
  endtask

  // ---------------------------------------------------------------- main
  initial begin
    vec_t tbl[$];
    bs_t  b;

    tbl.push_back(v(M_ONE, 1, 2'b10, 0, 10'h008, 32'hDEADBEEF, 1, 4'b1111, 32'hDEADBEEF, 2, 32'h0, 0));
    tbl.push_back(v(M_ONE, 0, 2'b10, 0, 10'h008, 32'h0,        1, 4'b1111, 32'h0, 2, 32'hDEADBEEF, 0));
    tbl.push_back(v(M_ONE, 1, 2'b00, 0, 10'h00B, 32'h00000080, 1, 4'b1000, 32'h80808080, 2, 32'h0, 0));
    tbl.push_back(v(M_ONE, 0, 2'b00, 1, 10'h00B, 32'h0, 1, 4'b1000, 32'h0, 2, 32'hFFFFFF80, 0));
    tbl.push_back(v(M_ONE, 0, 2'b00, 0, 10'h00B, 32'h0, 1, 4'b1000, 32'h0, 2, 32'h00000080, 0));
    tbl.push_back(v(M_ONE, 0, 2'b00, 1, 10'h009, 32'h0, 1, 4'b0010, 32'h0, 2, 32'hFFFFFFBE, 0));
    tbl.push_back(v(M_ONE, 0, 2'b00, 0, 10'h009, 32'h0, 1, 4'b0010, 32'h0, 2, 32'h000000BE, 0));
    tbl.push_back(v(M_ONE, 0, 2'b10, 1, 10'h008, 32'h0, 1, 4'b1111, 32'h0, 2, 32'h80ADBEEF, 0));
    tbl.push_back(v(M_ONE, 1, 2'b10, 0, 10'h010, 32'h80017FFF, 1, 4'b1111, 32'h80017FFF, 2, 32'h0, 0));
    tbl.push_back(v(M_ONE, 0, 2'b01, 1, 10'h012, 32'h0, 1, 4'b1100, 32'h0, 2, 32'hFFFF8001, 0));
    tbl.push_back(v(M_ONE, 0, 2'b01, 1, 10'h010, 32'h0, 1, 4'b0011, 32'h0, 2, 32'h00007FFF, 0));
    tbl.push_back(v(M_ONE, 0, 2'b01, 0, 10'h012, 32'h0, 1, 4'b1100, 32'h0, 2, 32'h00008001, 0));
    tbl.push_back(v(M_ONE, 1, 2'b01, 0, 10'h016, 32'h1234ABCD, 1, 4'b1100, 32'hABCDABCD, 2, 32'h0, 0));
    tbl.push_back(v(M_ONE, 0, 2'b01, 1, 10'h016, 32'h0, 1, 4'b1100, 32'h0, 2, 32'hFFFFABCD, 0));
    tbl.push_back(v(M_ONE, 1, 2'b00, 0, 10'h014, 32'h000000A5, 1, 4'b0001, 32'hA5A5A5A5, 2, 32'h0, 0));
    tbl.push_back(v(M_ONE, 0, 2'b10, 0, 10'h014, 32'h0, 1, 4'b1111, 32'h0, 2, 32'hABCD00A5, 0));
    // rejected: misaligned half, misaligned word, reserved size, misaligned stores
    tbl.push_back(v(M_ONE, 0, 2'b01, 0, 10'h001, 32'h0, 0, 4'b0000, 32'h0, 0, 32'h0, 1));
    tbl.push_back(v(M_ONE, 0, 2'b10, 0, 10'h002, 32'h0, 0, 4'b0000, 32'h0, 0, 32'h0, 1));
    tbl.push_back(v(M_ONE, 0, 2'b11, 0, 10'h004, 32'h0, 0, 4'b0000, 32'h0, 0, 32'h0, 1));
    tbl.push_back(v(M_ONE, 1, 2'b01, 0, 10'h003, 32'h5555, 0, 4'b0000, 32'h0, 0, 32'h0, 1));
    tbl.push_back(v(M_ONE, 1, 2'b10, 0, 10'h006, 32'h5555, 0, 4'b0000, 32'h0, 0, 32'h0, 1));
    // timeout, then a normal transfer
    tbl.push_back(v(M_NONE, 0, 2'b10, 0, 10'h020, 32'h0, 1, 4'b1111, 32'h0, 15, 32'h0, 1));
    tbl.push_back(v(M_ONE, 0, 2'b10, 0, 10'h010, 32'h0, 1, 4'b1111, 32'h0, 2, 32'h80017FFF, 0));
    // responder holding ack for two cycles, back-to-back requests
    tbl.push_back(v(M_HOLD, 1, 2'b10, 0, 10'h018, 32'hCAFEF00D, 1, 4'b1111, 32'hCAFEF00D, 2, 32'h0, 0));
    tbl.push_back(v(M_HOLD, 0, 2'b10, 0, 10'h018, 32'h0, 1, 4'b1111, 32'h0, 2, 32'hCAFEF00D, 0));
    tbl.push_back(v(M_HOLD, 0, 2'b00, 1, 10'h01B, 32'h0, 1, 4'b1000, 32'h0, 2, 32'hFFFFFFCA, 0));
    tbl.push_back(v(M_ONE, 0, 2'b10, 0, 10'h008, 32'h0, 1, 4'b1111, 32'h0, 2, 32'h80ADBEEF, 0));

    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mode = M_ONE;
    rst = 1'b1; req_valid = 1'b0; req_addr = 10'h0; req_we = 1'b0;
    req_size = 2'b00; req_signed = 1'b0; req_wdata = 32'h0;

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_stb", {31'd0, stb}, 32'd0);
    chk("rst_cyc", {31'd0, cyc}, 32'd0);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_resp_data", resp_data, 32'd0);
    chk("rst_resp_err", {31'd0, resp_err}, 32'd0);
    chk("rst_bus", {adr, sel, we, 19'd0}, 32'd0);
    chk("rst_dat_o", dat_o, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    foreach (tbl[i]) do_req(tbl[i]);

    // reset in the middle of a bus phase: strobe drops, no response follows
    mode = M_NONE;
    @(posedge clk); #1;
    req_we = 1'b0; req_size = 2'b10; req_signed = 1'b0; req_addr = 10'h024; req_valid = 1'b1;
    @(negedge clk);
    chk("mid_rst_ready", {31'd0, req_ready}, 32'd1);
    b.adr = 8'h09; b.sel = 4'b1111; b.we = 1'b0; b.dat = 32'h0; b.len = 3;
    bus_q.push_back(b);
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_stb_before", {31'd0, stb}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    chk("mid_rst_stb_after", {31'd0, stb}, 32'd0);
    chk("mid_rst_cyc_after", {31'd0, cyc}, 32'd0);
    chk("mid_rst_no_resp", {31'd0, resp_valid}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("post_rst_ready", {31'd0, req_ready}, 32'd1);
    end
    do_req(v(M_ONE, 0, 2'b10, 0, 10'h010, 32'h0, 1, 4'b1111, 32'h0, 2, 32'h80017FFF, 0));

    repeat (4) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
